imager_frame_arb: RTL

//  Frame-granular arbiter sharing one image pipeline among NUM_SRC imager receiver streams (dv/dtype/data).

---
 rtl/imager_frame_arb_pkg.sv | 25 ++
 rtl/imager_frame_arb_rr_pick.sv | 36 +++
 rtl/imager_frame_arb.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/imager_frame_arb_pkg.sv
// Shared stream token codes, arbitration modes and FSM state type for the
// imager frame arbiter and anything that drives or observes it.
package imager_frame_arb_pkg;

  localparam int DTYPE_WIDTH = 4;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_END  = 4'h5;

  localparam logic [1:0] ARB_MODE_FIXED      = 2'd0;
  localparam logic [1:0] ARB_MODE_RR         = 2'd1;
  localparam logic [1:0] ARB_MODE_FIRST_COME = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } arb_state_e;

  // Token that closes a frame, depending on whether frames carry a header.
  function automatic logic [DTYPE_WIDTH-1:0] end_token(input logic hdr);
    return hdr ? DTYPE_HEADER_END : DTYPE_FRAME_END;
  endfunction

endpackage

// File: rtl/imager_frame_arb_rr_pick.sv
// Combinational cyclic priority pick: first set request at or after ptr_i,
// returned as one-hot, index and valid flag.
module imager_rr_pick #(
  parameter int NUM_SRC   = 2,
  parameter int SEL_WIDTH = 2
) (
  input  logic [NUM_SRC-1:0]   req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic [NUM_SRC-1:0]   gnt_oh_o,
  output logic [SEL_WIDTH-1:0] gnt_idx_o,
  output logic                 gnt_vld_o
);

  int pos;

  // Walk offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    pos       = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i == pos && req_i[i]) begin
          gnt_oh_o    = '0;
          gnt_oh_o[i] = 1'b1;
          gnt_idx_o   = SEL_WIDTH'(i);
          gnt_vld_o   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imager_frame_arb.sv
// Frame-granular arbiter: grants one imager stream per frame, drops others whole.
// Define IMAGER_FRAME_ARB_TAG_EN to tag forwarded FRAME_START data with source and frame count.
module imager_frame_arb
  import imager_frame_arb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                           clki,
  input  logic                           reset_clki,
  input  logic                           enable,
  input  logic [1:0]                     mode,
  input  logic [SEL_WIDTH-1:0]           fixed_sel,
  input  logic [NUM_SRC-1:0]             src_mask,
  input  logic                           header_present,
  input  logic [NUM_SRC-1:0]             src_dv,
  input  logic [NUM_SRC*DTYPE_WIDTH-1:0] src_dtype,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_data,
  output logic                           dvo,
  output logic [DTYPE_WIDTH-1:0]         dtypeo,
  output logic [DATA_WIDTH-1:0]          datao,
  output logic [SEL_WIDTH-1:0]           grant_sel,
  output logic                           busy,
  output logic [15:0]                    frames_passed,
  output logic [15:0]                    frames_dropped,
  output logic [7:0]                     abort_count
);

  arb_state_e state_q, state_d;

  logic [NUM_SRC-1:0]     start_v, fixed_oh, grant_oh, pick_req, pick_oh, keep_oh;
  logic [SEL_WIDTH-1:0]   pick_idx, grant_q, grant_d, rr_ptr_q;
  logic                   pick_vld, take, hdr_q, hdr_d, g_dv, fwd, frame_done, abort_inc;
  logic [DTYPE_WIDTH-1:0] g_dtype, fwd_dtype, dtypeo_q;
  logic [DATA_WIDTH-1:0]  fwd_data, datao_q;
  logic [15:0]            drop_cnt, frames_passed_q, frames_dropped_q;
  logic [7:0]             abort_q;
  logic                   dvo_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign start_v[gi]  = src_dv[gi] &&
                            (src_dtype[gi*DTYPE_WIDTH +: DTYPE_WIDTH] == DTYPE_FRAME_START);
      assign fixed_oh[gi] = (fixed_sel == SEL_WIDTH'(gi));
      assign grant_oh[gi] = (grant_q == SEL_WIDTH'(gi));
    end
  endgenerate

  // In RR the picker chooses the single candidate; elsewhere it arbitrates among starters.
  always_comb begin
    pick_req = fixed_oh & src_mask & start_v;
    case (mode)
      ARB_MODE_RR:         pick_req = src_mask;
      ARB_MODE_FIRST_COME: pick_req = src_mask & start_v;
      default:             ;
    endcase
  end

  imager_rr_pick #(.NUM_SRC(NUM_SRC), .SEL_WIDTH(SEL_WIDTH)) u_pick (
    .req_i     (pick_req),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .gnt_vld_o (pick_vld)
  );

  assign take = enable && pick_vld && ((pick_oh & start_v) != '0);

  always_comb begin
    g_dv    = 1'b0;
    g_dtype = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_oh[i]) begin
        g_dv    = src_dv[i];
        g_dtype = src_dtype[i*DTYPE_WIDTH +: DTYPE_WIDTH];
      end
    end
  end

  always_ff @(posedge clki) begin
    if (reset_clki) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (take) state_d = ST_PASS;
      ST_PASS: if (frame_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    keep_oh    = take ? pick_oh : '0;
    fwd        = take;
    grant_d    = grant_q;
    hdr_d      = hdr_q;
    frame_done = 1'b0;
    abort_inc  = 1'b0;
    if (state_q == ST_PASS) begin
      keep_oh    = grant_oh;
      fwd        = g_dv;
      frame_done = g_dv && (g_dtype == end_token(hdr_q));
      abort_inc  = g_dv && (g_dtype == DTYPE_FRAME_START);
    end else if (take) begin
      grant_d = pick_idx;
      hdr_d   = header_present;
    end
  end

  always_comb begin
    fwd_dtype = '0;
    fwd_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (keep_oh[i]) begin
        fwd_dtype = src_dtype[i*DTYPE_WIDTH +: DTYPE_WIDTH];
        fwd_data  = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
`ifdef IMAGER_FRAME_ARB_TAG_EN
    if (fwd_dtype == DTYPE_FRAME_START)
      fwd_data = {grant_d, frames_passed_q[DATA_WIDTH-SEL_WIDTH-1:0]};
`endif
  end

  // Every FRAME_START on an eligible source that is not being forwarded is a dropped frame.
  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++)
      drop_cnt = drop_cnt + 16'(start_v[i] & src_mask[i] & ~keep_oh[i]);
  end

  always_ff @(posedge clki) begin
    if (reset_clki) begin
      dvo_q            <= 1'b0;
      dtypeo_q         <= '0;
      datao_q          <= '0;
      grant_q          <= '0;
      hdr_q            <= 1'b0;
      rr_ptr_q         <= '0;
      frames_passed_q  <= '0;
      frames_dropped_q <= '0;
      abort_q          <= '0;
    end else begin
      dvo_q            <= fwd;
      dtypeo_q         <= fwd ? fwd_dtype : '0;
      datao_q          <= fwd ? fwd_data : '0;
      grant_q          <= grant_d;
      hdr_q            <= hdr_d;
      frames_dropped_q <= frames_dropped_q + drop_cnt;
      if (frame_done) begin
        frames_passed_q <= frames_passed_q + 16'd1;
        rr_ptr_q        <= (grant_q == SEL_WIDTH'(NUM_SRC - 1)) ? '0 : grant_q + SEL_WIDTH'(1);
      end
      if (abort_inc && abort_q != 8'hFF) abort_q <= abort_q + 8'd1;
    end
  end

  assign dvo            = dvo_q;
  assign dtypeo         = dtypeo_q;
  assign datao          = datao_q;
  assign grant_sel      = grant_q;
  assign busy           = (state_q == ST_PASS);
  assign frames_passed  = frames_passed_q;
  assign frames_dropped = frames_dropped_q;
  assign abort_count    = abort_q;

endmodule
